sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//  Single-clock FIFO that is the DUT side of the f_interface wren/rden/wrdata protocol.
//  - Buffers 128-bit words written by the producer.
//  - Returns them in order to the consumer.
//  - Reports full/empty and almost-full/almost-empty levels.
//  Sits between a streaming producer and consumer. It is the block the UVM driver/monitor pair exercises.
// PARAMETERS
//  DATA_W      128  word width in bits
//  DEPTH       16   number of entries; power of 2, >= 4
//  AFULL_LVL   14   o_alm_full asserted when count >= AFULL_LVL (AEMPTY_LVL < AFULL_LVL <= DEPTH)
//  AEMPTY_LVL  2    o_alm_empty asserted when count <= AEMPTY_LVL (0 <= AEMPTY_LVL)
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rstn         in   1       synchronous reset, active-low
//  i_wren       in   1       write request
//  i_wrdata     in   DATA_W  write data, sampled with i_wren
//  i_rden       in   1       read request
//  o_rddata     out  DATA_W  read data, valid the cycle after an accepted read
//  o_full       out  1       count == DEPTH
//  o_empty      out  1       count == 0
//  o_alm_full   out  1       count >= AFULL_LVL
//  o_alm_empty  out  1       count <= AEMPTY_LVL
// BEHAVIOUR
//  Reset
//  - Synchronous: rstn low at posedge sets wr_ptr = rd_ptr = count = 0 and o_rddata = 0.
//  - Resulting flags: o_empty = 1, o_alm_empty = 1, o_full = 0, o_alm_full = 0.
//  - Storage array is not cleared.
//  - Reset mid-operation discards all contents and pending reads. The first read after reset sees only new writes.
//  Acceptance
//  - wr_acc = i_wren & !o_full.
//  - rd_acc = i_rden & !o_empty.
//  - Both use flag values present before the edge.
//  - A write while full is dropped: no pointer move, no data overwrite.
//  - A read while empty is dropped: o_rddata holds its previous value.
//  Simultaneous read and write
//  - Both accepted: count is unchanged and both pointers advance.
//  - When full, only the read is accepted (count -1).
//  - When empty, only the write is accepted (count +1). There is no write-through bypass.
//  Read latency
//  - 1 cycle: rd_acc at edge N puts mem[rd_ptr] on o_rddata after edge N.
//  - o_rddata holds until the next accepted read.
//  Write latency
//  - A word written at edge N is readable by rd_acc at edge N+1 at the earliest.
//  - o_empty deasserts after edge N.
//  Pointers and count
//  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//  - count is $clog2(DEPTH)+1 bits; next count = count + wr_acc - rd_acc.
//  Flags
//  - All four flags are registered. They are updated at the same edge as count and reflect the post-edge count.
//  - No combinational path from inputs to any output.
//  Invariants
//  - count never exceeds DEPTH and never underflows.
//  - o_full and o_empty are never both 1.
// STRUCTURE
//  - Package fifo_pkg holds:
//    - DATA_W localparam and typedef logic [DATA_W-1:0] data_t.
//    - Default DEPTH, AFULL_LVL and AEMPTY_LVL constants shared with the testbench.
//  - Sub-module fifo_mem: simple dual-port array of DEPTH x DATA_W.
//    - One write port (we, waddr, wdata).
//    - One registered read port (re, raddr, rdata) with synchronous active-low reset of rdata only.
//  - Top level: pointer/count logic, acceptance gating and flag registers.
// TESTING
//  1. Reset: hold rstn=0 3 cycles with i_wren=1 -> o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0.
//  2. Fill/drain: write 0x1..0x10 (16 words), then read 16 -> data returns 0x1..0x10 in order, 1 cycle after each read.
//     - o_alm_full rises after the 14th write; o_full after the 16th.
//     - o_alm_empty rises when count drops to 2; o_empty after the last read.
//  3. Overflow/underflow: 17th write of 0xDEAD while full -> dropped, last read still returns 0x10.
//     - Read when empty -> o_rddata holds 0x10 and count stays 0.
//  4. Simultaneous: at count=5, i_wren=i_rden=1 for 20 cycles -> count stays 5 and flags static, order preserved.
//     - At full with both asserted -> count goes to 15.
//     - At empty with both asserted -> count goes to 1, o_rddata unchanged.
//  5. Wrap: 3 passes of 12 writes/12 reads -> pointers wrap and data order is intact across the wrap.
//  6. Mid-op reset: count=9, pulse rstn low 1 cycle -> o_empty=1, o_rddata=0.
//     - Next write 0xA5 then read -> returns 0xA5.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and default geometry for the synchronous FIFO controller.
// The testbench imports the same constants so both sides agree on sizing.
package fifo_pkg;

   localparam int DATA_W = 128;

   typedef logic [DATA_W-1:0] data_t;

   localparam int DEF_DEPTH      = 16;
   localparam int DEF_AFULL_LVL  = 14;
   localparam int DEF_AEMPTY_LVL = 2;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// Only the read register is reset; the array contents survive reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  data_t             wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output data_t             rdata
);

   data_t mem_q [DEPTH];
   data_t rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // A same-edge write never targets the slot being read, so read-old is safe.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointer/count tracking, accept gating and registered flags.
// Flags are computed from the next count so they line up with the stored count.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AFULL_LVL  = DEF_AFULL_LVL,
   parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
   input  logic  clk,
   input  logic  rstn,
   input  logic  i_wren,
   input  data_t i_wrdata,
   input  logic  i_rden,
   output data_t o_rddata,
   output logic  o_full,
   output logic  o_empty,
   output logic  o_alm_full,
   output logic  o_alm_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, empty_q, alm_full_q, alm_empty_q;
   logic             wr_acc, rd_acc;

   assign wr_acc = i_wren & ~full_q;
   assign rd_acc = i_rden & ~empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         alm_full_q  <= 1'b0;
         alm_empty_q <= 1'b1;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= (count_d == CNT_W'(DEPTH));
         empty_q     <= (count_d == '0);
         alm_full_q  <= (count_d >= CNT_W'(AFULL_LVL));
         alm_empty_q <= (count_d <= CNT_W'(AEMPTY_LVL));
      end
   end

   fifo_mem #(
      .DEPTH (DEPTH),
      .ADDR_W(PTR_W)
   ) u_mem (
      .clk  (clk),
      .rstn (rstn),
      .we   (wr_acc),
      .waddr(wr_ptr_q),
      .wdata(i_wrdata),
      .re   (rd_acc),
      .raddr(rd_ptr_q),
      .rdata(o_rddata)
   );

   assign o_full      = full_q;
   assign o_empty     = empty_q;
   assign o_alm_full  = alm_full_q;
   assign o_alm_empty = alm_empty_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed plus randomized bench for sync_fifo_ctrl against a queue-based model.
module tb_sync_fifo_ctrl;
   import fifo_pkg::*;

   localparam int DEPTH = DEF_DEPTH;

   logic  clk = 1'b0;
   logic  rstn;
   logic  i_wren;
   data_t i_wrdata;
   logic  i_rden;
   data_t o_rddata;
   logic  o_full, o_empty, o_alm_full, o_alm_empty;

   int vectors    = 0;
   int miscompares = 0;

   data_t model_q[$];
   data_t exp_rd;

   sync_fifo_ctrl #(
      .DEPTH     (DEF_DEPTH),
      .AFULL_LVL (DEF_AFULL_LVL),
      .AEMPTY_LVL(DEF_AEMPTY_LVL)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_wren     (i_wren),
      .i_wrdata   (i_wrdata),
      .i_rden     (i_rden),
      .o_rddata   (o_rddata),
      .o_full     (o_full),
      .o_empty    (o_empty),
      .o_alm_full (o_alm_full),
      .o_alm_empty(o_alm_empty)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input data_t obs, input data_t exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic data_t rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock: apply inputs, advance the model, check all outputs after the edge.
   task automatic step(input logic we, input data_t wd, input logic re, input string tag);
      int  n;
      bit  wacc, racc;
      i_wren   = we;
      i_wrdata = wd;
      i_rden   = re;
      if (!rstn) begin
         model_q.delete();
         exp_rd = '0;
      end else begin
         n    = model_q.size();
         wacc = we && (n < DEPTH);
         racc = re && (n > 0);
         if (racc) exp_rd = model_q.pop_front();
         if (wacc) model_q.push_back(wd);
      end
      @(posedge clk);
      #1;
      n = model_q.size();
      chk({tag, ".rddata"},    o_rddata,    exp_rd);
      chk({tag, ".full"},      data_t'(o_full),      data_t'(n == DEPTH));
      chk({tag, ".empty"},     data_t'(o_empty),     data_t'(n == 0));
      chk({tag, ".alm_full"},  data_t'(o_alm_full),  data_t'(n >= DEF_AFULL_LVL));
      chk({tag, ".alm_empty"}, data_t'(o_alm_empty), data_t'(n <= DEF_AEMPTY_LVL));
      chk({tag, ".not_both"},  data_t'(o_full & o_empty), data_t'(0));
   endtask

   initial begin
      rstn     = 1'b0;
      i_wren   = 1'b0;
      i_rden   = 1'b0;
      i_wrdata = '0;
      exp_rd   = '0;
      @(negedge clk);

      // Reset held three cycles with write requested.
      for (int i = 0; i < 3; i++) step(1'b1, rnd_word(), 1'b0, "reset");
      rstn = 1'b1;

      // Fill with 1..16, attempt a write while full, then drain.
      for (int i = 1; i <= 16; i++) step(1'b1, data_t'(i), 1'b0, "fill");
      step(1'b1, data_t'(128'hDEAD), 1'b0, "overflow");
      for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, "drain");
      chk("drain_last", o_rddata, data_t'(128'h10));
      step(1'b0, '0, 1'b1, "underflow");
      step(1'b0, '0, 1'b1, "underflow2");

      // Simultaneous read/write at count 5, at full and at empty.
      for (int i = 0; i < 5; i++) step(1'b1, rnd_word(), 1'b0, "pre5");
      for (int i = 0; i < 20; i++) step(1'b1, rnd_word(), 1'b1, "simul5");
      for (int i = 0; i < 11; i++) step(1'b1, rnd_word(), 1'b0, "tofull");
      step(1'b1, rnd_word(), 1'b1, "simul_full");
      for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1, "toempty");
      step(1'b1, rnd_word(), 1'b1, "simul_empty");
      step(1'b0, '0, 1'b1, "simul_empty_rd");

      // Pointer wrap: three passes of 12 in / 12 out.
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 12; i++) step(1'b1, rnd_word(), 1'b0, "wrap_wr");
         for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, "wrap_rd");
      end

      // Randomized traffic with biased phases to visit both extremes.
      for (int i = 0; i < 400; i++) begin
         int bias;
         bias = (i / 100) % 2 == 0 ? 70 : 30;
         step(($urandom_range(99) < bias), rnd_word(), ($urandom_range(99) >= bias), "random");
      end

      // Mid-operation reset at count 9.
      while (model_q.size() > 0) step(1'b0, '0, 1'b1, "flush");
      for (int i = 0; i < 9; i++) step(1'b1, rnd_word(), 1'b0, "pre9");
      rstn = 1'b0;
      step(1'b0, '0, 1'b1, "midreset");
      rstn = 1'b1;
      step(1'b1, data_t'(128'hA5), 1'b0, "post_wr");
      step(1'b0, '0, 1'b1, "post_rd");
      chk("post_rd_data", o_rddata, data_t'(128'hA5));
      step(1'b0, '0, 1'b0, "idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
